// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack memory building blocks.
package hack_pkg;
  localparam int WORD_W = 16;
  localparam int DEPTH  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;
endpackage

// File: rtl/dmux8way.sv
// 8-way demultiplexer: routes a single bit to one of eight outputs.
module dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);
  assign a = in && (sel == 3'd0);
  assign b = in && (sel == 3'd1);
  assign c = in && (sel == 3'd2);
  assign d = in && (sel == 3'd3);
  assign e = in && (sel == 3'd4);
  assign f = in && (sel == 3'd5);
  assign g = in && (sel == 3'd6);
  assign h = in && (sel == 3'd7);
endmodule

// File: rtl/ram8_clear.sv
// Eight-word register bank with a sequential clear engine (one word per cycle)
// and a busy/done handshake.
module ram8_clear
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);
  clr_state_t       state;
  logic [2:0]       cnt;
  logic [DEPTH-1:0] load_sel;
  logic [DEPTH-1:0] wr_en;
  logic [DEPTH-1:0] clr_en;
  logic [WIDTH-1:0] mem [DEPTH];

  dmux8way u_dmux (
    .in  (load),
    .sel (address),
    .a   (load_sel[0]),
    .b   (load_sel[1]),
    .c   (load_sel[2]),
    .d   (load_sel[3]),
    .e   (load_sel[4]),
    .f   (load_sel[5]),
    .g   (load_sel[6]),
    .h   (load_sel[7])
  );

  // Writes are only honoured in IDLE; the clear engine owns the bank otherwise.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_en
    assign wr_en[gi]  = load_sel[gi] && (state == IDLE);
    assign clr_en[gi] = (state == CLEAR) && (cnt == 3'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i])
          mem[i] <= in;
        else if (clr_en[i])
          mem[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            cnt   <= 3'd0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb out = mem[address];
endmodule

// File: tb/tb_ram8_clear.sv
// Directed self-checking bench for ram8_clear.
module tb_ram8_clear;
  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;
  logic        done;

  int checks_total;
  int checks_passed;

  ram8_clear #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
      $display("check %-22s got=0x%0h exp=0x%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-22s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check(tag, {16'h0, out}, {16'h0, exp});
  endtask

  // Counts busy cycles until busy falls (bounded), leaving us just after E8.
  task automatic run_clear_count(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
  endtask

  task automatic fill_bank();
    for (int i = 0; i < 8; i++)
      write_word(3'(i), 16'(16'h1111 * (i + 1)));
  endtask

  initial begin
    int n;
    int done_seen;
    checks_total  = 0;
    checks_passed = 0;
    rst     = 1'b1;
    in      = '0;
    load    = 1'b0;
    address = '0;
    clear   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Mid-run asynchronous reset
    write_word(3'd1, 16'hCAFE);
    write_word(3'd6, 16'h0F0F);
    read_check("pre_rst_w1", 3'd1, 16'hCAFE);
    @(posedge clk);
    #2 rst = 1'b1;
    #2;
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++)
      read_check($sformatf("rst_word%0d", i), 3'(i), 16'h0000);

    // Basic writes
    write_word(3'd3, 16'h1234);
    write_word(3'd7, 16'hBEEF);
    for (int i = 0; i < 8; i++)
      read_check($sformatf("wr_word%0d", i), 3'(i),
                 (i == 3) ? 16'h1234 : (i == 7) ? 16'hBEEF : 16'h0000);

    // Full clear sequence
    fill_bank();
    read_check("fill_word4", 3'd4, 16'h5555);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy_E0", {31'h0, busy}, 32'd1);
    check("clr_done_E0", {31'h0, done}, 32'd0);
    read_check("clr_word0_E0", 3'd0, 16'h1111);
    run_clear_count(n);
    check("clr_busy_cycles", n, 32'd8);
    check("clr_done_E8", {31'h0, done}, 32'd1);
    check("clr_busy_E8", {31'h0, busy}, 32'd0);
    tick();
    check("clr_done_E9", {31'h0, done}, 32'd0);
    for (int i = 0; i < 8; i++)
      read_check($sformatf("clr_word%0d", i), 3'(i), 16'h0000);

    // Load during cycle 3 of CLEAR is dropped
    write_word(3'd5, 16'h1357);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
    address = 3'd5;
    in      = 16'hAAAA;
    load    = 1'b1;
    clear   = 1'b1;
    tick();
    load    = 1'b0;
    clear   = 1'b0;
    read_check("drop_word5_mid", 3'd5, 16'h1357);
    run_clear_count(n);
    check("drop_busy_cycles", n, 32'd5);
    check("drop_done", {31'h0, done}, 32'd1);
    tick();
    check("drop_no_restart", {31'h0, busy}, 32'd0);
    read_check("drop_word5_end", 3'd5, 16'h0000);

    // Load together with clear in IDLE
    address = 3'd2;
    in      = 16'h5555;
    load    = 1'b1;
    clear   = 1'b1;
    tick();
    load    = 1'b0;
    clear   = 1'b0;
    read_check("ldclr_word2_E0", 3'd2, 16'h5555);
    check("ldclr_busy", {31'h0, busy}, 32'd1);
    run_clear_count(n);
    check("ldclr_busy_cycles", n, 32'd8);
    check("ldclr_done", {31'h0, done}, 32'd1);
    read_check("ldclr_word2_end", 3'd2, 16'h0000);
    tick();

    // Reset during cycle 4 of CLEAR
    fill_bank();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (3) tick();
    read_check("abort_word7_pre", 3'd7, 16'h8888);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_done", {31'h0, done}, 32'd0);
    for (int i = 0; i < 8; i++)
      read_check($sformatf("abort_word%0d", i), 3'(i), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
